// File: rtl/ife_block_arbiter_if.sv
// Bundle of requester-side and queue-side signals for the IFE block arbiter.
// master = the arbiter itself, slave = producers/queue environment.
interface ife_block_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int BLOCK_ID_WIDTH = 8,
  parameter int INSTR_WIDTH    = 32,
  parameter int BLOCK_SIZE     = 4
);
  localparam int GRANT_W = $clog2(NUM_REQ);

  logic                                              flush;
  logic [NUM_REQ-1:0]                                req_valid;
  logic [NUM_REQ-1:0]                                req_ready;
  logic [NUM_REQ-1:0][BLOCK_ID_WIDTH-1:0]            req_block_id;
  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][INSTR_WIDTH-1:0] req_block;
  logic                                              q_valid;
  logic                                              q_ready;
  logic [BLOCK_ID_WIDTH-1:0]                         q_block_id;
  logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0]            q_block;
  logic [GRANT_W-1:0]                                q_grant_idx;

  modport master (
    input  flush, req_valid, req_block_id, req_block, q_ready,
    output req_ready, q_valid, q_block_id, q_block, q_grant_idx
  );

  modport slave (
    output flush, req_valid, req_block_id, req_block, q_ready,
    input  req_ready, q_valid, q_block_id, q_block, q_grant_idx
  );
endinterface

// File: rtl/ife_block_arbiter.sv
// Round-robin arbiter feeding the IFE block queue through a single output register.
// Optional IFE_ARB_ID_STAMP_EN: stamp loaded blocks with a local wrapping id counter.
module ife_block_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int BLOCK_ID_WIDTH = 8,
  parameter int INSTR_WIDTH    = 32,
  parameter int BLOCK_SIZE     = 4
) (
  input  logic                clk,
  input  logic                rst,
  ife_block_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);

  logic                                   r_q_valid;
  logic [BLOCK_ID_WIDTH-1:0]              r_q_block_id;
  logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0] r_q_block;
  logic [GW-1:0]                          r_q_grant_idx;
  logic [GW-1:0]                          r_rr_ptr;

  logic                      w_load_en;
  logic                      w_found;
  logic                      w_load;
  logic [GW-1:0]             w_win;
  logic [GW-1:0]             w_win_next;
  logic [NUM_REQ-1:0][GW-1:0] w_cand;
  logic [BLOCK_ID_WIDTH-1:0] w_sel_id;

  // Reset is folded in so req_ready is low while rst is held.
  assign w_load_en  = !rst && !bus.flush && (!r_q_valid || bus.q_ready);
  assign w_load     = w_load_en && w_found;
  assign w_win_next = (w_win == GW'(NUM_REQ - 1)) ? {GW{1'b0}} : (w_win + GW'(1));

  // Candidate index k of the scan order, starting at rr_ptr and wrapping at NUM_REQ.
  always_comb begin
    w_cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (({1'b0, r_rr_ptr} + (GW+1)'(k)) >= (GW+1)'(NUM_REQ)) begin
        w_cand[k] = GW'({1'b0, r_rr_ptr} + (GW+1)'(k) - (GW+1)'(NUM_REQ));
      end else begin
        w_cand[k] = GW'({1'b0, r_rr_ptr} + (GW+1)'(k));
      end
    end
  end

  // First valid requester in scan order wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = {GW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.req_valid[w_cand[k]]) begin
        w_found = 1'b1;
        w_win   = w_cand[k];
      end else begin
        w_found = w_found;
        w_win   = w_win;
      end
    end
  end

  // One-hot acceptance strobe back to the winning producer.
  always_comb begin
    bus.req_ready = {NUM_REQ{1'b0}};
    if (w_load) begin
      bus.req_ready[w_win] = 1'b1;
    end else begin
      bus.req_ready = {NUM_REQ{1'b0}};
    end
  end

`ifdef IFE_ARB_ID_STAMP_EN
  logic [BLOCK_ID_WIDTH-1:0] r_id_cnt;

  // Id counter advances once per accepted block and wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_cnt <= {BLOCK_ID_WIDTH{1'b0}};
    end else if (w_load) begin
      r_id_cnt <= r_id_cnt + BLOCK_ID_WIDTH'(1);
    end else begin
      r_id_cnt <= r_id_cnt;
    end
  end

  assign w_sel_id = r_id_cnt;
`else
  assign w_sel_id = bus.req_block_id[w_win];
`endif

  // Output register and round-robin pointer; flush drops the held block without loading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_valid     <= 1'b0;
      r_q_block_id  <= {BLOCK_ID_WIDTH{1'b0}};
      r_q_block     <= '0;
      r_q_grant_idx <= {GW{1'b0}};
      r_rr_ptr      <= {GW{1'b0}};
    end else if (bus.flush) begin
      r_q_valid <= 1'b0;
    end else if (w_load) begin
      r_q_valid     <= 1'b1;
      r_q_block_id  <= w_sel_id;
      r_q_block     <= bus.req_block[w_win];
      r_q_grant_idx <= w_win;
      r_rr_ptr      <= w_win_next;
    end else if (w_load_en) begin
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= r_q_valid;
    end
  end

  assign bus.q_valid     = r_q_valid;
  assign bus.q_block_id  = r_q_block_id;
  assign bus.q_block     = r_q_block;
  assign bus.q_grant_idx = r_q_grant_idx;
endmodule

// File: tb/tb_ife_block_arbiter.sv
// Scoreboard bench: driver predicts each accepted block from a round-robin model,
// a separate monitor pops and compares whenever the registered block is presented.
module tb_ife_block_arbiter;
  localparam int N  = 4;
  localparam int BW = 8;
  localparam int IW = 32;
  localparam int BS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ife_block_arbiter_if #(.NUM_REQ(N), .BLOCK_ID_WIDTH(BW), .INSTR_WIDTH(IW), .BLOCK_SIZE(BS)) bus ();

  ife_block_arbiter #(.NUM_REQ(N), .BLOCK_ID_WIDTH(BW), .INSTR_WIDTH(IW), .BLOCK_SIZE(BS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int              idx;
    logic [BW-1:0]   id;
    logic [BS*IW-1:0] blk;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int m_rr  = 0;
  int m_id  = 0;

  task automatic chk(input string nm, input logic [BS*IW-1:0] act, input logic [BS*IW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: the front entry is the block that should be sitting in the output register.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        chk("q_valid", 128'(bus.q_valid), 128'(sb.size() > 0));
        if (bus.q_valid && sb.size() > 0) begin
          chk("q_grant_idx", 128'(bus.q_grant_idx), 128'(sb[0].idx));
          chk("q_block_id", 128'(bus.q_block_id), 128'(sb[0].id));
          chk("q_block", bus.q_block, sb[0].blk);
          if (bus.q_ready || bus.flush) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic [N-1:0] rv, input logic fl, input logic qr, input logic rs);
    exp_t e;
    int w;
    bit ld;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst            = rs;
    bus.req_valid  = rv;
    bus.flush      = fl;
    bus.q_ready    = qr;
    for (int i = 0; i < N; i++) begin
      bus.req_block_id[i] = BW'($urandom);
      for (int j = 0; j < BS; j++) bus.req_block[i][j] = $urandom;
    end
    exp_rdy = '0;
    ld      = 1'b0;
    w       = -1;
    if (rs) begin
      sb.delete();
      m_rr = 0;
      m_id = 0;
    end else if (!fl && (sb.size() == 0 || qr)) begin
      for (int k = 0; k < N; k++) begin
        int j = (m_rr + k) % N;
        if (w < 0 && rv[j]) w = j;
      end
      if (w >= 0) begin
        ld         = 1'b1;
        exp_rdy[w] = 1'b1;
        e.idx      = w;
`ifdef IFE_ARB_ID_STAMP_EN
        e.id       = BW'(m_id);
`else
        e.id       = bus.req_block_id[w];
`endif
        e.blk      = bus.req_block[w];
      end
    end
    #2;
    chk("req_ready", 128'(bus.req_ready), 128'(exp_rdy));
    if (rs) begin
      chk("rst_q_valid", 128'(bus.q_valid), 128'(0));
      chk("rst_q_grant_idx", 128'(bus.q_grant_idx), 128'(0));
    end
    #1;
    if (ld) begin
      sb.push_back(e);
      m_rr = (w + 1) % N;
      m_id = (m_id + 1) % (1 << BW);
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.flush        = 1'b0;
    bus.q_ready      = 1'b0;
    bus.req_valid    = '0;
    bus.req_block_id = '0;
    bus.req_block    = '0;

    repeat (2) cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    repeat (8) cyc(4'b1111, 1'b0, 1'b1, 1'b0);
    repeat (4) cyc(4'b1010, 1'b0, 1'b1, 1'b0);
    cyc(4'b1111, 1'b0, 1'b1, 1'b0);
    repeat (5) cyc(4'b1111, 1'b0, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0, 1'b0);
    repeat (4) cyc(4'b1111, 1'b0, 1'b1, 1'b0);
    cyc(4'b0110, 1'b0, 1'b1, 1'b1);
    repeat (3) cyc(4'b0110, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      cyc(N'($urandom), ($urandom % 10) == 0, ($urandom % 3) != 0, ($urandom % 250) == 0);
    end

    repeat (4) cyc(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("drained", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
